song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Parametrised playback controller for the music-player datapath.
- Walks the song ROM address and counts each note's duration in beat ticks.
- Detects end of song, either from a zero-duration terminator or from the address wrapping past the last entry.
- Emits a single-cycle song_done pulse; supports pause/resume, repeat mode, and an optional inter-note gap.
- Sits between the beat divider, the song ROM (1-cycle read latency) and the tone generator (gated by note_en).

Parameters:
- ADDR_W, 5, ROM address width; song length up to 2^ADDR_W notes (default 32).
- DUR_W, 6, duration field width in beats; 0 means end of song.
- GAP_BEATS, 0, silent beats inserted after each note (0 = no gap); width DUR_W.

Ports:
- clk  in  1  system clock.
- r  in  1  synchronous active-high reset.
- play  in  1  start/resume request, level-sampled each cycle.
- pause  in  1  pause request; overrides play when both are high.
- repeat_en  in  1  at end of song, restart from address 0 instead of stopping.
- beat  in  1  one-cycle beat tick enable from the divider.
- dur_in  in  DUR_W  duration read from ROM at addr; valid one cycle after addr changes.
- addr  out  ADDR_W  ROM address of the current note.
- note_en  out  1  high while a note is sounding; gates the tone generator.
- busy  out  1  high in every state except IDLE.
- song_done  out  1  one-cycle pulse at end of song.

Behaviour:
- Reset (r=1 at posedge clk), regardless of state: state=IDLE, addr=0, counters=0, note_en=0, busy=0, song_done=0.
- All outputs are registered.

States and transitions:
- IDLE: addr held at 0. play=1 and pause=0 -> FETCH.
- FETCH: one-cycle wait for ROM latency. Next cycle -> LOAD.
- LOAD:
  - dur_in==0 -> END.
  - Otherwise latch dur_cnt=dur_in -> PLAY.
- PLAY:
  - note_en=1.
  - On beat, dur_cnt decrements.
  - When beat arrives with dur_cnt==1: if GAP_BEATS>0 -> GAP (gap_cnt=GAP_BEATS), else -> ADV.
- GAP: note_en=0. On beat, gap_cnt decrements; at beat with gap_cnt==1 -> ADV.
- ADV:
  - addr==2^ADDR_W-1 -> END (wrap counts as end).
  - Otherwise addr=addr+1 -> FETCH.
- END:
  - song_done=1 for exactly this one cycle; note_en=0.
  - addr=0.
  - repeat_en=1 -> FETCH; else -> IDLE.
- PAUSED:
  - Entered from FETCH/LOAD/PLAY/GAP/ADV when pause=1.
  - note_en=0; all counters and addr frozen; beats ignored.
  - play=1 and pause=0 -> returns to the saved state.
  - PAUSED->FETCH resume always re-fetches, because dur_in may have been disturbed.

Timing and boundary conditions:
- Latency: play sampled -> note_en high after 3 cycles (FETCH, LOAD, PLAY entry).
- Note length: dur_in beats exactly. Beat coincident with LOAD entry is not counted.
- pause and play both high: pause wins.
- pause asserted in END: ignored; the song_done pulse still fires.
- repeat_en is sampled only in END.
- Beat arriving in FETCH/LOAD/ADV/END: ignored, no backlog.
- dur_in==0 at addr 0: END immediately, single song_done, no note_en.
- r asserted mid-note: note_en drops next cycle; no song_done pulse.
- Counter width: dur_cnt and gap_cnt are DUR_W bits and never underflow.

Decomposition:
- Shared package song_pkg holds:
  - state enum (IDLE, FETCH, LOAD, PLAY, GAP, ADV, END, PAUSED);
  - default ADDR_W and DUR_W;
  - END_DUR=0 terminator constant.
- One sub-module, beat_down_counter: loadable DUR_W down-counter with beat enable, freeze input, and an is_one flag. It is instantiated twice, for duration and gap.

Test Plan:
- ROM {3,2,0}, GAP_BEATS=0, play pulse, beat every 4 clk -> note_en high 3 beats at addr0 then 2 beats at addr1; song_done single pulse when addr=2 loads; addr returns 0; busy falls.
- ROM all 1s with ADDR_W=2 (4 entries), repeat_en=0 -> addr steps 0,1,2,3; song_done pulse after addr3 note; state IDLE.
- ROM {2,0}, repeat_en=1 -> song_done pulses every loop; addr sequence 0,1,0,1...; note_en pattern periodic.
- Pause mid note (dur 5, pause after 2 beats, 10 beats held, then play) -> note_en low during pause; after resume the note lasts exactly 3 more beats.
- GAP_BEATS=1, ROM {2,2,0} -> note_en 2 beats, low 1 beat, 2 beats; song_done once.
- r asserted during PLAY at addr 3 -> next cycle addr=0, note_en=0, song_done=0, busy=0; ROM {0} with play -> immediate song_done pulse, note_en never high.

Source files
------------

// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared state encoding and constants for the song sequencer
package song_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP,
    ADV,
    END,
    PAUSED
  } song_state_t;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DUR_W  = 6;
  // A zero duration in the ROM marks the end of the song.
  localparam int END_DUR    = 0;

endpackage

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - control, ROM and tone-gate signals of the song sequencer
interface song_sequencer_if
  import song_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DUR_W  = DEF_DUR_W
);

  logic              play;
  logic              pause;
  logic              repeat_en;
  logic              beat;
  logic [DUR_W-1:0]  dur_in;
  logic [ADDR_W-1:0] addr;
  logic              note_en;
  logic              busy;
  logic              song_done;

  modport master (
    output play, pause, repeat_en, beat, dur_in,
    input  addr, note_en, busy, song_done
  );

  modport slave (
    input  play, pause, repeat_en, beat, dur_in,
    output addr, note_en, busy, song_done
  );

endinterface

// File: rtl/beat_down_counter.sv
// rtl/beat_down_counter.sv - loadable beat-driven down-counter that stops at zero
module beat_down_counter
  import song_pkg::*;
#(
  parameter int DUR_W = DEF_DUR_W
) (
  input  logic             clk,
  input  logic             r,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             beat,
  input  logic             freeze,
  output logic             is_one
);

  logic [DUR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (r) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (beat && !freeze && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == DUR_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - walks the song ROM, times notes in beats and gates the tone generator
module song_sequencer
  import song_pkg::*;
#(
  parameter int               ADDR_W    = DEF_ADDR_W,
  parameter int               DUR_W     = DEF_DUR_W,
  parameter logic [DUR_W-1:0] GAP_BEATS = '0
) (
  input logic              clk,
  input logic              r,
  song_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  song_state_t state;
  song_state_t resume_st;
  logic        dur_one;
  logic        gap_one;
  logic        dur_is_end;
  logic        dur_load;
  logic        note_done;
  logic        gap_done;

  assign dur_is_end = (bus.dur_in == DUR_W'(END_DUR));
  assign dur_load   = (state == LOAD) && !bus.pause && !dur_is_end;
  assign note_done  = (state == PLAY) && !bus.pause && bus.beat && dur_one;
  assign gap_done   = (state == GAP)  && !bus.pause && bus.beat && gap_one;

  beat_down_counter #(.DUR_W(DUR_W)) u_dur (
    .clk      (clk),
    .r        (r),
    .load     (dur_load),
    .load_val (bus.dur_in),
    .beat     (bus.beat),
    .freeze   (state != PLAY || bus.pause),
    .is_one   (dur_one)
  );

  beat_down_counter #(.DUR_W(DUR_W)) u_gap (
    .clk      (clk),
    .r        (r),
    .load     (note_done),
    .load_val (GAP_BEATS),
    .beat     (bus.beat),
    .freeze   (state != GAP || bus.pause),
    .is_one   (gap_one)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      state         <= IDLE;
      resume_st     <= IDLE;
      bus.addr      <= '0;
      bus.note_en   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.song_done <= 1'b0;
    end else begin
      bus.song_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.play && !bus.pause) begin
            state    <= FETCH;
            bus.busy <= 1'b1;
          end
        end
        END: begin
          if (bus.repeat_en) begin
            state <= FETCH;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        // A pause caught in LOAD resumes through FETCH so dur_in is re-read.
        PAUSED: begin
          if (bus.play && !bus.pause) begin
            state       <= (resume_st == LOAD) ? FETCH : resume_st;
            bus.note_en <= (resume_st == PLAY);
          end
        end
        default: begin
          if (bus.pause) begin
            state       <= PAUSED;
            resume_st   <= state;
            bus.note_en <= 1'b0;
          end else begin
            case (state)
              FETCH: state <= LOAD;
              LOAD: begin
                if (dur_is_end) begin
                  state         <= END;
                  bus.addr      <= '0;
                  bus.song_done <= 1'b1;
                end else begin
                  state       <= PLAY;
                  bus.note_en <= 1'b1;
                end
              end
              PLAY: begin
                if (note_done) begin
                  state       <= (GAP_BEATS != '0) ? GAP : ADV;
                  bus.note_en <= 1'b0;
                end
              end
              GAP: begin
                if (gap_done) state <= ADV;
              end
              ADV: begin
                if (bus.addr == LAST_ADDR) begin
                  state         <= END;
                  bus.addr      <= '0;
                  bus.song_done <= 1'b1;
                end else begin
                  state    <= FETCH;
                  bus.addr <= bus.addr + 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer
module tb_song_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r, sel, play, pause, repeat_en, beat;
  logic [5:0] rom_a [4];
  logic [5:0] rom_b [32];
  int checks = 0;
  int failures = 0;

  song_sequencer_if #(.ADDR_W(2), .DUR_W(6)) ifa ();
  song_sequencer_if #(.ADDR_W(5), .DUR_W(6)) ifb ();

  song_sequencer #(.ADDR_W(2), .DUR_W(6), .GAP_BEATS(6'd0)) dut_a (
    .clk (clk), .r (r), .bus (ifa.slave)
  );
  song_sequencer #(.ADDR_W(5), .DUR_W(6), .GAP_BEATS(6'd1)) dut_b (
    .clk (clk), .r (r), .bus (ifb.slave)
  );

  assign ifa.play      = play & ~sel;
  assign ifa.pause     = pause & ~sel;
  assign ifa.repeat_en = repeat_en & ~sel;
  assign ifa.beat      = beat & ~sel;
  assign ifb.play      = play & sel;
  assign ifb.pause     = pause & sel;
  assign ifb.repeat_en = repeat_en & sel;
  assign ifb.beat      = beat & sel;

  // Song ROMs with one cycle of read latency.
  always @(posedge clk) begin
    ifa.dur_in <= rom_a[ifa.addr];
    ifb.dur_in <= rom_b[ifb.addr];
  end

  logic [4:0] o_addr;
  logic o_en, o_busy, o_done;
  assign o_addr = sel ? ifb.addr : {3'b000, ifa.addr};
  assign o_en   = sel ? ifb.note_en : ifa.note_en;
  assign o_busy = sel ? ifb.busy : ifa.busy;
  assign o_done = sel ? ifb.song_done : ifa.song_done;

  typedef struct packed {
    logic sel;
    int   loops;
    int   d0, d1, d2, d3;
    int   pause_after;
    int   pause_beats;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int rom_at(input logic s, input int i);
    logic [4:0] ib;
    ib = i[4:0];
    if (s) return int'(rom_b[ib]);
    return (i < 4) ? int'(rom_a[ib[1:0]]) : 0;
  endfunction

  task automatic run_song(input vec_t v, input bit rnd, input string tag);
    int n, term, dones, lat, en_bad, addr_bad, off_bad, off_run, pcnt, rcnt, pstate, leak;
    int gapb, bad, k, ord_bad;
    int beats_at [32];
    int starts [$];
    int exp_starts [$];
    bit prev_en, new_loop, finishing, ended;
    n = v.sel ? 32 : 4;
    gapb = v.sel ? 1 : 0;
    term = n;
    for (int i = n - 1; i >= 0; i--) if (rom_at(v.sel, i) == 0) term = i;
    foreach (beats_at[i]) beats_at[i] = 0;
    sel = v.sel; repeat_en = (v.loops > 1); play = 0; pause = 0; beat = 0;
    r = 1; repeat (2) @(posedge clk); #1; r = 0;
    play = 1;
    dones = 0; lat = -1; en_bad = 0; addr_bad = 0; off_bad = 0; off_run = 0;
    pcnt = 0; rcnt = 0; pstate = 0; leak = 0;
    prev_en = 0; new_loop = 1; finishing = 0; ended = 0;
    for (int cyc = 1; cyc <= 4000 && !ended; cyc++) begin
      @(posedge clk); #1;
      if (lat < 0 && (o_en || o_done)) lat = cyc;
      if (o_en && o_addr >= term) en_bad++;
      if (o_en && !prev_en) begin
        if (new_loop || o_addr != starts[$]) begin
          if (!new_loop && !rnd && off_run != 4 * gapb + 3) off_bad++;
          starts.push_back(int'(o_addr));
        end
        new_loop = 0;
      end
      if (!o_en) off_run = prev_en ? 1 : off_run + 1;
      if (o_done) begin
        dones++;
        new_loop = 1;
        if (o_addr != 0) addr_bad++;
        if (dones >= v.loops) begin
          repeat_en = 0; play = 0; pause = 0; finishing = 1; rcnt = 0;
        end
      end
      if (finishing && !o_busy) ended = 1;
      if (pstate == 1) begin
        if (o_en) leak++;
        pcnt--;
        if (pcnt == 0) begin pause = 0; pstate = 2; end
      end else if (pstate == 0 && v.pause_after > 0 && o_en && beats_at[0] == v.pause_after) begin
        pause = 1; pcnt = v.pause_beats * 4; pstate = 1;
      end
      if (rnd && !finishing) begin
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) pause = 0;
        end else if ($urandom_range(0, 29) == 0) begin
          pause = 1; rcnt = $urandom_range(1, 6);
        end
      end
      beat = rnd ? ($urandom_range(0, 2) == 0) : ((cyc % 4) == 0);
      if (o_en && beat && !pause) beats_at[o_addr]++;
      prev_en = o_en;
    end
    beat = 0; play = 0; pause = 0; repeat_en = 0;
    check({tag, "_timeout"}, 32'(ended), 32'd1);
    check({tag, "_done_count"}, dones, v.loops);
    check({tag, "_done_addr"}, addr_bad, 0);
    check({tag, "_en_past_end"}, en_bad, 0);
    check({tag, "_en_at_end"}, 32'(o_en), 32'd0);
    bad = -1;
    for (int i = n - 1; i >= 0; i--)
      if (beats_at[i] != ((i < term) ? rom_at(v.sel, i) * v.loops : 0)) bad = i;
    k = (bad >= 0) ? bad : 0;
    check({tag, "_note_beats"}, beats_at[k], (k < term) ? rom_at(v.sel, k) * v.loops : 0);
    for (int l = 0; l < v.loops; l++) for (int i = 0; i < term; i++) exp_starts.push_back(i);
    check({tag, "_note_count"}, starts.size(), exp_starts.size());
    ord_bad = 0;
    for (int i = 0; i < starts.size() && i < exp_starts.size(); i++)
      if (starts[i] != exp_starts[i]) ord_bad++;
    check({tag, "_note_order"}, ord_bad, 0);
    if (!rnd) begin
      check({tag, "_latency"}, lat, 3);
      check({tag, "_gap_cycles"}, off_bad, 0);
    end
    if (v.pause_after > 0) begin
      check({tag, "_pause_taken"}, pstate, 2);
      check({tag, "_en_while_paused"}, leak, 0);
    end
  endtask

  vec_t vecs [7];
  vec_t rv;
  bit seen;
  int late_bad;

  initial begin
    vecs[0] = '{sel: 1'b0, loops: 1, d0: 3, d1: 2, d2: 0, d3: 0, pause_after: 0, pause_beats: 0};
    vecs[1] = '{sel: 1'b0, loops: 1, d0: 1, d1: 1, d2: 1, d3: 1, pause_after: 0, pause_beats: 0};
    vecs[2] = '{sel: 1'b0, loops: 3, d0: 2, d1: 0, d2: 0, d3: 0, pause_after: 0, pause_beats: 0};
    vecs[3] = '{sel: 1'b0, loops: 1, d0: 5, d1: 0, d2: 0, d3: 0, pause_after: 2, pause_beats: 10};
    vecs[4] = '{sel: 1'b1, loops: 1, d0: 2, d1: 2, d2: 0, d3: 0, pause_after: 0, pause_beats: 0};
    vecs[5] = '{sel: 1'b0, loops: 1, d0: 0, d1: 3, d2: 3, d3: 3, pause_after: 0, pause_beats: 0};
    vecs[6] = '{sel: 1'b1, loops: 2, d0: 1, d1: 3, d2: 1, d3: 0, pause_after: 0, pause_beats: 0};

    r = 1; sel = 0; play = 0; pause = 0; repeat_en = 0; beat = 0;
    foreach (rom_a[i]) rom_a[i] = '0;
    foreach (rom_b[i]) rom_b[i] = '0;
    repeat (2) @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check($sformatf("reset%0d_addr", s), 32'(o_addr), 32'd0);
      check($sformatf("reset%0d_note_en", s), 32'(o_en), 32'd0);
      check($sformatf("reset%0d_busy", s), 32'(o_busy), 32'd0);
      check($sformatf("reset%0d_song_done", s), 32'(o_done), 32'd0);
    end
    r = 0;

    foreach (vecs[t]) begin
      foreach (rom_a[i]) rom_a[i] = '0;
      foreach (rom_b[i]) rom_b[i] = '0;
      if (vecs[t].sel) begin
        rom_b[0] = vecs[t].d0[5:0]; rom_b[1] = vecs[t].d1[5:0];
        rom_b[2] = vecs[t].d2[5:0]; rom_b[3] = vecs[t].d3[5:0];
      end else begin
        rom_a[0] = vecs[t].d0[5:0]; rom_a[1] = vecs[t].d1[5:0];
        rom_a[2] = vecs[t].d2[5:0]; rom_a[3] = vecs[t].d3[5:0];
      end
      run_song(vecs[t], 1'b0, $sformatf("vec%0d", t));
    end

    for (int t = 0; t < 8; t++) begin
      rv = '{sel: t[0], loops: 1, d0: 0, d1: 0, d2: 0, d3: 0, pause_after: 0, pause_beats: 0};
      foreach (rom_a[i]) rom_a[i] = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 3));
      foreach (rom_b[i]) rom_b[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 3));
      run_song(rv, 1'b1, $sformatf("rnd%0d", t));
    end

    // Reset while the last note of a four-note song is sounding.
    rom_a = '{6'd2, 6'd2, 6'd2, 6'd5};
    sel = 0; repeat_en = 0; pause = 0; beat = 0;
    r = 1; @(posedge clk); #1; r = 0; play = 1;
    seen = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (o_en && o_addr == 5'd3) seen = 1;
      else beat = ((c % 4) == 0);
    end
    check("rst_mid_reach_addr3", 32'(seen), 32'd1);
    r = 1;
    @(posedge clk); #1;
    r = 0; play = 0; beat = 0;
    check("rst_mid_addr", 32'(o_addr), 32'd0);
    check("rst_mid_note_en", 32'(o_en), 32'd0);
    check("rst_mid_song_done", 32'(o_done), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    late_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o_done || o_busy || o_en) late_bad++;
    end
    check("rst_mid_stays_idle", late_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
